// File: rtl/vga_pkg.sv
// ============================================================================
// vga_pkg : pattern-mode encoding and 640x480@60 default timing constants
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package vga_pkg;

   typedef enum logic [1:0] {
      MODE_BARS    = 2'd0,
      MODE_CHECKER = 2'd1,
      MODE_EXT     = 2'd2,
      MODE_BLACK   = 2'd3
   } vga_mode_e;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_CLK_DIV  = 2;
   localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

endpackage

`default_nettype wire

// File: rtl/vga_sync_counter.sv
// ============================================================================
// vga_sync_counter : pixel-clock divider plus horizontal/vertical counters
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module vga_sync_counter
   import vga_pkg::*;
#(
   parameter int H_TOTAL = VGA_H_TOTAL,
   parameter int V_TOTAL = VGA_V_TOTAL,
   parameter int CLK_DIV = VGA_CLK_DIV
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       o_tick,
   output logic                       o_vgaclk,
   output logic [$clog2(H_TOTAL)-1:0] o_hcnt,
   output logic [$clog2(V_TOTAL)-1:0] o_vcnt,
   output logic                       o_h_wrap,
   output logic                       o_v_wrap
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int HW    = $clog2(H_TOTAL);
   localparam int VW    = $clog2(V_TOTAL);

   logic [DIV_W-1:0] r_div_cnt;
   logic [DIV_W-1:0] w_div_next;
   logic             w_tick;
   logic             r_vgaclk;
   logic [HW-1:0]    r_hcnt;
   logic [VW-1:0]    r_vcnt;

   assign w_tick     = (r_div_cnt == DIV_W'(CLK_DIV - 1));
   assign w_div_next = w_tick ? '0 : r_div_cnt + 1'b1;
   assign o_h_wrap   = (r_hcnt == HW'(H_TOTAL - 1));
   assign o_v_wrap   = (r_vcnt == VW'(V_TOTAL - 1));
   assign o_tick     = w_tick;
   assign o_vgaclk   = r_vgaclk;
   assign o_hcnt     = r_hcnt;
   assign o_vcnt     = r_vcnt;

   // vgaclk follows the next divider value so it falls on the same edge the pixel outputs update
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div_cnt <= '0;
         r_vgaclk  <= 1'b0;
         r_hcnt    <= '0;
         r_vcnt    <= '0;
      end else begin
         r_div_cnt <= w_div_next;
         r_vgaclk  <= (w_div_next >= DIV_W'(CLK_DIV / 2));
         if (w_tick) begin
            if (o_h_wrap) begin
               r_hcnt <= '0;
               r_vcnt <= o_v_wrap ? '0 : r_vcnt + 1'b1;
            end else begin
               r_hcnt <= r_hcnt + 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// vga_timing_gen : VGA sync/blank generator with test patterns and external pixel path
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE  = VGA_H_ACTIVE,
   parameter int   H_FP      = VGA_H_FP,
   parameter int   H_SYNC    = VGA_H_SYNC,
   parameter int   H_BP      = VGA_H_BP,
   parameter int   V_ACTIVE  = VGA_V_ACTIVE,
   parameter int   V_FP      = VGA_V_FP,
   parameter int   V_SYNC    = VGA_V_SYNC,
   parameter int   V_BP      = VGA_V_BP,
   parameter int   CLK_DIV   = VGA_CLK_DIV,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0,
   parameter int   COLOR_W   = 8
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [1:0]                                     mode,
   input  logic [COLOR_W-1:0]                             pix_r,
   input  logic [COLOR_W-1:0]                             pix_g,
   input  logic [COLOR_W-1:0]                             pix_b,
   output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]   x,
   output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]   y,
   output logic                                           vgaclk,
   output logic                                           hsync,
   output logic                                           vsync,
   output logic                                           sync_b,
   output logic                                           blank_b,
   output logic [COLOR_W-1:0]                             r,
   output logic [COLOR_W-1:0]                             g,
   output logic [COLOR_W-1:0]                             b,
   output logic                                           frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   logic               w_tick;
   logic [HW-1:0]      w_hcnt;
   logic [VW-1:0]      w_vcnt;
   logic               w_h_wrap;
   logic               w_v_wrap;
   logic               w_active;
   logic               w_hsync_on;
   logic               w_vsync_on;
   logic [2:0]         w_bar;
   logic               w_chk;
   logic [COLOR_W-1:0] w_r;
   logic [COLOR_W-1:0] w_g;
   logic [COLOR_W-1:0] w_b;

   vga_mode_e          r_mode_q;
   logic               r_hsync;
   logic               r_vsync;
   logic               r_blank_b;
   logic [COLOR_W-1:0] r_r;
   logic [COLOR_W-1:0] r_g;
   logic [COLOR_W-1:0] r_b;
   logic               r_frame_start;

   vga_sync_counter #(
      .H_TOTAL (H_TOTAL),
      .V_TOTAL (V_TOTAL),
      .CLK_DIV (CLK_DIV)
   ) u_sync_counter (
      .clk      (clk),
      .rst      (rst),
      .o_tick   (w_tick),
      .o_vgaclk (vgaclk),
      .o_hcnt   (w_hcnt),
      .o_vcnt   (w_vcnt),
      .o_h_wrap (w_h_wrap),
      .o_v_wrap (w_v_wrap)
   );

   assign w_active   = (w_hcnt < HW'(H_ACTIVE)) && (w_vcnt < VW'(V_ACTIVE));
   assign w_hsync_on = (w_hcnt >= HW'(H_ACTIVE + H_FP)) && (w_hcnt < HW'(H_ACTIVE + H_FP + H_SYNC));
   assign w_vsync_on = (w_vcnt >= VW'(V_ACTIVE + V_FP)) && (w_vcnt < VW'(V_ACTIVE + V_FP + V_SYNC));
   assign w_bar      = 3'((32'(w_hcnt) * 32'd8) / 32'(H_ACTIVE));
   assign w_chk      = w_hcnt[5] ^ w_vcnt[5];

   always_comb begin
      w_r = '0;
      w_g = '0;
      w_b = '0;
      if (w_active) begin
         case (r_mode_q)
            MODE_BARS: begin
               w_r = {COLOR_W{w_bar[2]}};
               w_g = {COLOR_W{w_bar[1]}};
               w_b = {COLOR_W{w_bar[0]}};
            end
            MODE_CHECKER: begin
               w_r = {COLOR_W{w_chk}};
               w_g = {COLOR_W{w_chk}};
               w_b = {COLOR_W{w_chk}};
            end
            MODE_EXT: begin
               w_r = pix_r;
               w_g = pix_g;
               w_b = pix_b;
            end
            default: begin
               w_r = '0;
               w_g = '0;
               w_b = '0;
            end
         endcase
      end
   end

   // All pixel outputs take the pre-increment coordinate so they stay mutually aligned
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode_q      <= vga_mode_e'(mode);
         r_hsync       <= ~HSYNC_POL;
         r_vsync       <= ~VSYNC_POL;
         r_blank_b     <= 1'b0;
         r_r           <= '0;
         r_g           <= '0;
         r_b           <= '0;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= 1'b0;
         if (w_tick) begin
            r_hsync       <= w_hsync_on ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= w_vsync_on ? VSYNC_POL : ~VSYNC_POL;
            r_blank_b     <= w_active;
            r_r           <= w_r;
            r_g           <= w_g;
            r_b           <= w_b;
            r_frame_start <= (w_hcnt == '0) && (w_vcnt == '0);
            if (w_h_wrap && w_v_wrap) begin
               r_mode_q <= vga_mode_e'(mode);
            end
         end
      end
   end

   assign x           = w_hcnt;
   assign y           = w_vcnt;
   assign sync_b      = 1'b0;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign blank_b     = r_blank_b;
   assign r           = r_r;
   assign g           = r_g;
   assign b           = r_b;
   assign frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// tb_vga_timing_gen : directed checks of timing, patterns, mode shadowing and reset
// Rev 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_timing_gen;

   // Shrunken raster (80 x 56 totals) so several frames fit in a short run
   localparam int H_ACTIVE = 64;
   localparam int H_FP     = 4;
   localparam int H_SYNC   = 8;
   localparam int H_BP     = 4;
   localparam int V_ACTIVE = 48;
   localparam int V_FP     = 2;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode;
   logic [7:0] pix_r, pix_g, pix_b;
   logic [6:0] x;
   logic [5:0] y;
   logic       vgaclk, hsync, vsync, sync_b, blank_b, frame_start;
   logic [7:0] r, g, b;

   int checks = 0;
   int errors = 0;
   bit drive_ext = 1'b0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
      .CLK_DIV (2), .HSYNC_POL (1'b0), .VSYNC_POL (1'b0), .COLOR_W (8)
   ) dut (
      .clk (clk), .rst (rst), .mode (mode),
      .pix_r (pix_r), .pix_g (pix_g), .pix_b (pix_b),
      .x (x), .y (y), .vgaclk (vgaclk), .hsync (hsync), .vsync (vsync),
      .sync_b (sync_b), .blank_b (blank_b), .r (r), .g (g), .b (b),
      .frame_start (frame_start)
   );

   // External pixel source answers the current x/y well before the next tick
   task automatic step_clk();
      @(posedge clk);
      #1;
      if (drive_ext) begin
         pix_r = 8'(x);
         pix_g = 8'(y);
         pix_b = 8'hA5;
      end
   endtask

   // Parks on the first clk in which pixel (h,v) is on the outputs (counters already at h+1)
   task automatic goto(input int h, input int v, input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         if (!vgaclk && int'(x) == h + 1 && int'(y) == v) begin
            ok = 1'b1;
            break;
         end
         step_clk();
      end
      if (!ok) begin errors++; $display("FAIL %s timeout waiting for pixel (%0d,%0d)", name, h, v); end
      checks++;
   endtask

   task automatic test_reset();
      rst = 1'b1; mode = 2'd0; pix_r = '0; pix_g = '0; pix_b = '0;
      repeat (3) step_clk();
      if ({hsync, vsync, blank_b, frame_start, vgaclk, sync_b} !== 6'b110000) begin
         errors++; $display("FAIL reset_ctrl got %b want 110000", {hsync, vsync, blank_b, frame_start, vgaclk, sync_b});
      end
      checks++;
      if ({r, g, b} !== 24'h0) begin errors++; $display("FAIL reset_rgb got %h want 000000", {r, g, b}); end
      checks++;
      if (x !== 7'd0 || y !== 6'd0) begin errors++; $display("FAIL reset_xy got %0d,%0d want 0,0", x, y); end
      checks++;
   endtask

   task automatic test_first_pixel();
      int n;
      n = 0;
      rst = 1'b0;
      while (!frame_start && n < 20) begin step_clk(); n++; end
      if (n !== 2) begin errors++; $display("FAIL first_fs_latency got %0d want 2", n); end
      checks++;
      if (x !== 7'd1 || y !== 6'd0) begin errors++; $display("FAIL first_xy got %0d,%0d want 1,0", x, y); end
      checks++;
      if ({blank_b, vgaclk, hsync, vsync} !== 4'b1011) begin
         errors++; $display("FAIL first_ctrl got %b want 1011", {blank_b, vgaclk, hsync, vsync});
      end
      checks++;
      if ({r, g, b} !== 24'h0) begin errors++; $display("FAIL first_rgb got %h want 000000", {r, g, b}); end
      checks++;
      step_clk();
      if ({frame_start, vgaclk} !== 2'b01) begin errors++; $display("FAIL fs_width_vgaclk got %b want 01", {frame_start, vgaclk}); end
      checks++;
   endtask

   task automatic test_line();
      int blank_n, hs_n, hs_first;
      logic [2:0]  bar;
      logic [23:0] exp_rgb;
      blank_n = 0; hs_n = 0; hs_first = -1;
      goto(0, 1, "line_start");
      for (int k = 0; k < 80; k++) begin
         bar = 3'(k / 8);
         exp_rgb = (k < 64) ? {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}} : 24'h0;
         if ({r, g, b} !== exp_rgb) begin errors++; $display("FAIL bars_px%0d got %h want %h", k, {r, g, b}, exp_rgb); end
         checks++;
         if (blank_b) blank_n++;
         if (!hsync) begin hs_n++; if (hs_first < 0) hs_first = k; end
         step_clk(); step_clk();
      end
      if (blank_n !== 64) begin errors++; $display("FAIL blank_ticks got %0d want 64", blank_n); end
      checks++;
      if (hs_n !== 8) begin errors++; $display("FAIL hsync_ticks got %0d want 8", hs_n); end
      checks++;
      if (hs_first !== 68) begin errors++; $display("FAIL hsync_start got %0d want 68", hs_first); end
      checks++;
      if (x !== 7'd1 || y !== 6'd2 || !blank_b) begin
         errors++; $display("FAIL line_period got x=%0d y=%0d blank=%b want 1,2,1", x, y, blank_b);
      end
      checks++;
   endtask

   task automatic test_frame();
      int n, vs_n, vs_line;
      n = 0; vs_n = 0; vs_line = -1;
      while (!frame_start && n < 10000) begin step_clk(); n++; end
      if (!frame_start) begin errors++; $display("FAIL frame_sync got 0 want frame_start"); end
      checks++;
      n = 0;
      do begin
         step_clk(); n++;
         if (!vsync) begin vs_n++; if (vs_line < 0) vs_line = int'(y); end
      end while (!frame_start && n < 10000);
      if (n !== 8960) begin errors++; $display("FAIL frame_period got %0d want 8960", n); end
      checks++;
      if (vs_n !== 320) begin errors++; $display("FAIL vsync_clks got %0d want 320", vs_n); end
      checks++;
      if (vs_line !== 50) begin errors++; $display("FAIL vsync_line got %0d want 50", vs_line); end
      checks++;
   endtask

   task automatic test_mode_switch();
      goto(5, 10, "ms_switch");
      mode = 2'd1;
      goto(40, 20, "ms_bars");
      if ({r, g, b} !== 24'hFF00FF) begin errors++; $display("FAIL ms_bars_hold got %h want FF00FF", {r, g, b}); end
      checks++;
      goto(70, 40, "ms_blank");
      if ({blank_b, r, g, b} !== 25'h0) begin errors++; $display("FAIL ms_blank got %h want 0", {blank_b, r, g, b}); end
      checks++;
      goto(0, 0, "ms_origin");
      if ({frame_start, r, g, b} !== 25'h1000000) begin
         errors++; $display("FAIL chk_origin got %h want 1000000", {frame_start, r, g, b});
      end
      checks++;
      goto(32, 0, "ms_32_0");
      if ({r, g, b} !== 24'hFFFFFF) begin errors++; $display("FAIL chk_32_0 got %h want FFFFFF", {r, g, b}); end
      checks++;
      goto(0, 32, "ms_0_32");
      if ({r, g, b} !== 24'hFFFFFF) begin errors++; $display("FAIL chk_0_32 got %h want FFFFFF", {r, g, b}); end
      checks++;
      goto(32, 32, "ms_32_32");
      if ({r, g, b} !== 24'h000000) begin errors++; $display("FAIL chk_32_32 got %h want 000000", {r, g, b}); end
      checks++;
   endtask

   task automatic test_ext();
      drive_ext = 1'b1;
      mode = 2'd2;
      goto(0, 0, "ext_origin");
      goto(60, 7, "ext_60_7");
      if ({r, g, b} !== 24'h3C07A5) begin errors++; $display("FAIL ext_60_7 got %h want 3C07A5", {r, g, b}); end
      checks++;
      goto(65, 7, "ext_blank");
      if ({blank_b, r, g, b} !== 25'h0) begin errors++; $display("FAIL ext_blank got %h want 0", {blank_b, r, g, b}); end
      checks++;
      goto(10, 50, "ext_vblank");
      if ({blank_b, r, g, b} !== 25'h0) begin errors++; $display("FAIL ext_vblank got %h want 0", {blank_b, r, g, b}); end
      checks++;
   endtask

   task automatic test_black();
      mode = 2'd3;
      goto(0, 0, "blk_origin");
      goto(10, 10, "blk_10_10");
      if ({blank_b, r, g, b} !== 25'h1000000) begin
         errors++; $display("FAIL black_px got %h want 1000000", {blank_b, r, g, b});
      end
      checks++;
   endtask

   task automatic test_mid_reset();
      int n, k;
      goto(20, 30, "rst_point");
      rst = 1'b1;
      mode = 2'd0;
      step_clk();
      if ({hsync, vsync, blank_b, frame_start, vgaclk} !== 5'b11000) begin
         errors++; $display("FAIL midrst_ctrl got %b want 11000", {hsync, vsync, blank_b, frame_start, vgaclk});
      end
      checks++;
      if (x !== 7'd0 || y !== 6'd0 || {r, g, b} !== 24'h0) begin
         errors++; $display("FAIL midrst_state got x=%0d y=%0d rgb=%h want 0,0,0", x, y, {r, g, b});
      end
      checks++;
      step_clk(); step_clk();
      rst = 1'b0;
      n = 0;
      while (!frame_start && n < 20) begin step_clk(); n++; end
      if (n !== 2) begin errors++; $display("FAIL midrst_fs got %0d want 2", n); end
      checks++;
      k = 0;
      while (hsync && k < 200) begin
         if (k == 8) begin
            if ({r, g, b} !== 24'h0000FF) begin errors++; $display("FAIL midrst_mode got %h want 0000FF", {r, g, b}); end
            checks++;
         end
         step_clk(); step_clk();
         k++;
      end
      if (k !== 68) begin errors++; $display("FAIL midrst_hsync got %0d want 68", k); end
      checks++;
   endtask

   initial begin
      test_reset();
      test_first_pixel();
      test_line();
      test_frame();
      test_mode_switch();
      test_ext();
      test_black();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
